// File: rtl/pcm_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// pcm_frame_scheduler_if
// Per-channel PCM beat stream from the frame scheduler to its consumer.
//   out_data   sample of the current channel
//   out_chan   channel index of out_data
//   out_valid  beat valid (source)
//   out_ready  consumer ready (sink)
//   out_first  channel-0 beat of a frame
//   out_last   channel-(N-1) beat of a frame
// master = scheduler side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pcm_frame_scheduler_if #(
   parameter int W  = 16,
   parameter int CW = 7
);
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_chan;
   logic          out_valid;
   logic          out_ready;
   logic          out_first;
   logic          out_last;

   modport master (
      output out_data, out_chan, out_valid, out_first, out_last,
      input  out_ready
   );

   modport slave (
      input  out_data, out_chan, out_valid, out_first, out_last,
      output out_ready
   );
endinterface

// File: rtl/pcm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// pcm_frame_scheduler
// Snapshots the N PCM words of the decimation array on each output-rate
// strobe and streams them one channel per beat over a valid/ready stream,
// so the decimators never stall on a slow consumer. Numbers frames and
// counts frames that arrive before the previous one has drained.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   enable    accept new frames when high
//   pcm_in    flattened PCM bus, channel k at pcm_in[k*W +: W]
//   pcm_stb   one-cycle strobe: pcm_in holds a new sample set
//   out_if    beat stream (master modport)
//   frame_id  number of the frame being sent, wraps 0xFFFF -> 0
//   busy      frame in progress
//   ovf       sticky dropped-frame flag
//   ovf_clr   clears ovf and drop_cnt
//   drop_cnt  dropped-frame count, saturating at 255
// ---------------------------------------------------------------------------
module pcm_frame_scheduler #(
   parameter  int N  = 96,
   parameter  int W  = 16,
   localparam int CW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [N*W-1:0]        pcm_in,
   input  logic                  pcm_stb,
   pcm_frame_scheduler_if.master out_if,
   output logic [15:0]           frame_id,
   output logic                  busy,
   output logic                  ovf,
   input  logic                  ovf_clr,
   output logic [7:0]            drop_cnt
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t        state, state_next;
   logic [CW-1:0] chan, chan_next;
   logic [W-1:0]  shadow [N];
   logic          started;      // a frame has been accepted since reset
   logic          first_q, last_q;

   logic          xfer;
   logic          last_beat;
   logic          snap;
   logic          drop;
   logic [7:0]    drop_base;
   logic [7:0]    drop_cnt_next;

   assign xfer      = (state == SEND) && out_if.out_ready;
   assign last_beat = (chan == CW'(N - 1));

   // Next-state logic. A strobe is taken either from IDLE or on the very
   // edge that transfers the last beat; any other enabled strobe while a
   // frame is in flight is a drop and leaves the shadow bank untouched.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      chan_next  = chan;
      snap       = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (pcm_stb && enable) begin
               snap       = 1'b1;
               chan_next  = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (xfer && !last_beat) begin
               chan_next = chan + CW'(1);
            end else if (xfer && last_beat) begin
               chan_next = '0;
               if (pcm_stb && enable) begin
                  snap = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            if (pcm_stb && enable && !(xfer && last_beat)) begin
               drop = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Clear first, then count, so a drop on the clearing edge still shows.
   assign drop_base     = ovf_clr ? 8'd0 : drop_cnt;
   assign drop_cnt_next = (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         chan     <= '0;
         started  <= 1'b0;
         frame_id <= '0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state    <= state_next;
         chan     <= chan_next;
         first_q  <= (state_next == SEND) && (chan_next == '0);
         last_q   <= (state_next == SEND) && (chan_next == CW'(N - 1));
         ovf      <= drop | (ovf & ~ovf_clr);
         drop_cnt <= drop_cnt_next;
         if (snap) begin
            started <= 1'b1;
            if (started) frame_id <= frame_id + 16'd1;
         end
      end
   end

   // NOTE: the shadow bank is a flop array, not a RAM, and must read as zero
   // after reset, so it sits in the reset branch; a RAM-style memory would
   // normally be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) shadow[k] <= '0;
      end else if (snap) begin
         for (int k = 0; k < N; k++) shadow[k] <= pcm_in[k*W +: W];
      end
   end

   // out_data is the only combinational output: a mux of the shadow bank.
   assign out_if.out_data  = shadow[chan];
   assign out_if.out_chan  = chan;
   assign out_if.out_valid = (state == SEND);
   assign out_if.out_first = first_q;
   assign out_if.out_last  = last_q;
   assign busy             = (state == SEND);

endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pcm_frame_scheduler
// Directed bench for pcm_frame_scheduler: single frame, backpressure,
// dropped frame, back-to-back frames, enable gating, mid-frame reset and
// drop counter saturation.
// ---------------------------------------------------------------------------
module tb_pcm_frame_scheduler;
   localparam int N  = 96;
   localparam int W  = 16;
   localparam int CW = 7;

   logic           clk     = 1'b0;
   logic           rst     = 1'b0;
   logic           enable  = 1'b0;
   logic           pcm_stb = 1'b0;
   logic           ovf_clr = 1'b0;
   logic [N*W-1:0] pcm_in  = '0;
   logic [15:0]    frame_id;
   logic           busy;
   logic           ovf;
   logic [7:0]     drop_cnt;

   int checks   = 0;
   int failures = 0;

   pcm_frame_scheduler_if #(.W(W), .CW(CW)) bus ();

   pcm_frame_scheduler #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .pcm_in   (pcm_in),
      .pcm_stb  (pcm_stb),
      .out_if   (bus),
      .frame_id (frame_id),
      .busy     (busy),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] pat(input logic [15:0] base);
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = base + 16'(k);
      return v;
   endfunction

   // Consume beats until stop_after transfers. mode 0: ready always high,
   // mode 1: ready pattern 1,0,0,1. When the transfer of channel stb_at is
   // about to happen, pcm_stb is pulsed with pcm_in = pat(stb_base).
   task automatic drain(input logic [15:0] base, input logic [15:0] exp_id,
                        input int mode, input int stb_at,
                        input logic [15:0] stb_base, input int stop_after);
      int            exp_chan = 0;
      int            cyc      = 0;
      logic          stalled  = 1'b0;
      logic [W-1:0]  h_data   = '0;
      logic [CW-1:0] h_chan   = '0;
      logic          h_first  = 1'b0;
      logic          h_last   = 1'b0;
      logic [15:0]   h_id     = '0;
      logic [15:0]   exp_data;
      while (exp_chan < stop_after && cyc < 2000) begin
         pcm_stb       = 1'b0;
         bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (stalled && bus.out_valid) begin
            check("hold_data",  32'(bus.out_data),  32'(h_data));
            check("hold_chan",  32'(bus.out_chan),  32'(h_chan));
            check("hold_first", 32'(bus.out_first), 32'(h_first));
            check("hold_last",  32'(bus.out_last),  32'(h_last));
            check("hold_id",    32'(frame_id),      32'(h_id));
         end
         if (bus.out_valid && bus.out_ready) begin
            exp_data = base + 16'(exp_chan);
            check("beat_data",  32'(bus.out_data),  32'(exp_data));
            check("beat_chan",  32'(bus.out_chan),  32'(exp_chan));
            check("beat_first", 32'(bus.out_first), 32'(exp_chan == 0));
            check("beat_last",  32'(bus.out_last),  32'(exp_chan == N - 1));
            check("beat_id",    32'(frame_id),      32'(exp_id));
            if (exp_chan == stb_at) begin
               pcm_stb = 1'b1;
               pcm_in  = pat(stb_base);
            end
            exp_chan++;
            stalled = 1'b0;
         end else if (bus.out_valid) begin
            stalled = 1'b1;
            h_data  = bus.out_data;
            h_chan  = bus.out_chan;
            h_first = bus.out_first;
            h_last  = bus.out_last;
            h_id    = frame_id;
         end else begin
            stalled = 1'b0;
         end
         step();
         cyc++;
      end
      pcm_stb       = 1'b0;
      bus.out_ready = 1'b1;
      check("drain_beats", 32'(exp_chan), 32'(stop_after));
   endtask

   task automatic start_frame(input logic [15:0] base);
      pcm_in  = pat(base);
      pcm_stb = 1'b1;
      step();
      pcm_stb = 1'b0;
   endtask

   initial begin
      int vcount;
      bus.out_ready = 1'b1;

      // Reset state
      #1;
      check("rst_valid",    32'(bus.out_valid), 32'd0);
      check("rst_busy",     32'(busy),          32'd0);
      check("rst_ovf",      32'(ovf),           32'd0);
      check("rst_drop",     32'(drop_cnt),      32'd0);
      check("rst_id",       32'(frame_id),      32'd0);
      check("rst_chan",     32'(bus.out_chan),  32'd0);
      check("rst_data",     32'(bus.out_data),  32'd0);
      check("rst_first",    32'(bus.out_first), 32'd0);
      check("rst_last",     32'(bus.out_last),  32'd0);
      repeat (2) step();
      rst    = 1'b1;
      enable = 1'b1;
      step();

      // Single frame with strobe-to-beat latency of one cycle
      pcm_in  = pat(16'h1000);
      pcm_stb = 1'b1;
      check("lat_pre_valid", 32'(bus.out_valid), 32'd0);
      step();
      pcm_stb = 1'b0;
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      check("lat_busy",  32'(busy),          32'd1);
      drain(16'h1000, 16'd0, 0, -1, 16'h0, N);
      check("f0_idle_valid", 32'(bus.out_valid), 32'd0);
      check("f0_idle_busy",  32'(busy),          32'd0);
      check("f0_ovf",        32'(ovf),           32'd0);

      // Backpressure
      start_frame(16'h2000);
      drain(16'h2000, 16'd1, 1, -1, 16'h0, N);
      check("bp_idle", 32'(bus.out_valid), 32'd0);

      // Strobe mid-frame is dropped; current frame stays intact
      start_frame(16'h3000);
      drain(16'h3000, 16'd2, 0, 40, 16'h4000, N);
      check("drop_ovf",   32'(ovf),           32'd1);
      check("drop_cnt",   32'(drop_cnt),      32'd1);
      check("drop_idle",  32'(bus.out_valid), 32'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("clr_ovf",  32'(ovf),      32'd0);
      check("clr_cnt",  32'(drop_cnt), 32'd0);

      // Strobe on the last-beat transfer: no bubble
      start_frame(16'h5000);
      drain(16'h5000, 16'd3, 0, N - 1, 16'h6000, N);
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_chan",  32'(bus.out_chan),  32'd0);
      check("b2b_data",  32'(bus.out_data),  32'h6000);
      check("b2b_first", 32'(bus.out_first), 32'd1);
      check("b2b_id",    32'(frame_id),      32'd4);
      check("b2b_ovf",   32'(ovf),           32'd0);
      drain(16'h6000, 16'd4, 0, -1, 16'h0, N);
      check("b2b_idle", 32'(bus.out_valid), 32'd0);

      // enable low: strobes ignored, no overflow
      enable = 1'b0;
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         pcm_in  = pat(16'h7700);
         pcm_stb = 1'b1;
         step();
         pcm_stb = 1'b0;
         for (int c = 0; c < 63; c++) begin
            if (bus.out_valid) vcount++;
            step();
         end
      end
      check("en_lo_valid", 32'(vcount), 32'd0);
      check("en_lo_ovf",   32'(ovf),    32'd0);
      check("en_lo_id",    32'(frame_id), 32'd4);

      // enable dropped mid-frame: frame completes, then IDLE
      enable = 1'b1;
      start_frame(16'h7000);
      enable = 1'b0;
      drain(16'h7000, 16'd5, 0, N - 1, 16'h7800, N);
      check("en_mid_idle", 32'(bus.out_valid), 32'd0);
      check("en_mid_ovf",  32'(ovf),           32'd0);
      check("en_mid_id",   32'(frame_id),      32'd5);
      enable = 1'b1;

      // Reset at beat 50 aborts asynchronously
      start_frame(16'h8000);
      drain(16'h8000, 16'd6, 0, -1, 16'h0, 50);
      check("pre_rst_chan", 32'(bus.out_chan), 32'd50);
      #2;
      rst = 1'b0;
      #1;
      check("async_valid", 32'(bus.out_valid), 32'd0);
      check("async_busy",  32'(busy),          32'd0);
      check("async_id",    32'(frame_id),      32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      start_frame(16'h9000);
      check("post_rst_id",    32'(frame_id),      32'd0);
      check("post_rst_chan",  32'(bus.out_chan),  32'd0);
      check("post_rst_first", 32'(bus.out_first), 32'd1);
      check("post_rst_data",  32'(bus.out_data),  32'h9000);
      drain(16'h9000, 16'd0, 0, -1, 16'h0, N);

      // 300 forced drops saturate drop_cnt
      start_frame(16'hA000);
      bus.out_ready = 1'b0;
      pcm_in        = pat(16'hB000);
      pcm_stb       = 1'b1;
      repeat (300) step();
      check("sat_cnt",   32'(drop_cnt),      32'd255);
      check("sat_ovf",   32'(ovf),           32'd1);
      check("sat_chan",  32'(bus.out_chan),  32'd0);
      check("sat_valid", 32'(bus.out_valid), 32'd1);
      ovf_clr = 1'b1;
      step();
      check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
      check("clr_drop_ovf", 32'(ovf),      32'd1);
      pcm_stb = 1'b0;
      step();
      ovf_clr = 1'b0;
      check("clr2_cnt", 32'(drop_cnt), 32'd0);
      check("clr2_ovf", 32'(ovf),      32'd0);
      drain(16'hA000, 16'd1, 0, -1, 16'h0, N);
      check("end_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcm_frame_scheduler.md
Name: pcm_frame_scheduler

Overview:
- Sequences the output side of the N-channel PDM-to-PCM decimation array.
- On each output-rate sample strobe, snapshots all N PCM words into a shadow bank, then streams them one channel per beat over a valid/ready interface, so the decimators keep running while a downstream consumer (beamformer, FIFO or host link) drains at its own pace.
- Tracks frame numbering and detects frames that arrive before the previous one has drained.

Parameters:
- N, 96, number of PDM/PCM channels.
- W, 16, PCM sample width.
- CW, $clog2(N), channel index width (derived; do not override).

Ports:
- clk  in  1  system clock (3.125 MHz domain of the decimation array).
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  accept new frames when high.
- pcm_in  in  N*W  flattened PCM bus; channel k is pcm_in[k*W +: W].
- pcm_stb  in  1  one-cycle strobe: pcm_in holds a new output-rate sample set.
- out_data  out  W  current channel sample.
- out_chan  out  CW  channel index of out_data.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_first  out  1  high on the channel-0 beat.
- out_last  out  1  high on the channel-N-1 beat.
- frame_id  out  16  number of the frame being sent; wraps 0xFFFF->0.
- busy  out  1  frame in progress.
- ovf  out  1  sticky: a frame was dropped.
- ovf_clr  in  1  clears ovf.
- drop_cnt  out  8  dropped-frame count, saturates at 255, cleared by ovf_clr.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; out_valid, out_first, out_last, busy and ovf are 0; out_data, out_chan, frame_id and drop_cnt are 0; shadow bank is 0.
- Beat transfer occurs when out_valid and out_ready are both high at a rising clk edge.
- While out_valid is high and out_ready is low, out_data, out_chan, out_first, out_last and frame_id hold stable.
- FSM has two states: IDLE and SEND.
- IDLE:
  - If pcm_stb && enable, snapshot pcm_in into the shadow bank on that edge, set chan=0, and go to SEND.
  - out_valid rises the next cycle: 1-cycle latency from strobe to the channel-0 beat.
  - frame_id increments on every accepted frame except the first after reset, so the first frame is id 0.
- SEND:
  - out_valid=1; out_data = shadow[chan]; out_first=(chan==0); out_last=(chan==N-1).
  - On a transfer with chan<N-1: chan increments.
  - On a transfer with chan==N-1: if pcm_stb && enable on the same edge, snapshot, chan=0, frame_id+1, and stay in SEND with no bubble. Otherwise go to IDLE.
  - pcm_stb in SEND other than on the last-beat transfer edge: frame dropped, shadow not overwritten, ovf set, drop_cnt+1 (saturating). The current frame continues unaffected.
- enable low:
  - New strobes are ignored; this is not an overflow.
  - A frame in progress always completes.
- ovf_clr and a drop on the same edge: set/increment wins, so ovf=1 and drop_cnt=1.
- busy = (state==SEND).
- Reset asserted mid-frame aborts immediately: out_valid drops asynchronously and the partial frame is discarded.
- No combinational path from out_ready to out_valid.
- Only out_data depends combinationally on registered state (mux of shadow by chan). All other outputs are registered.

Test Plan:
- Reset then single strobe with pcm_in ch k = 0x1000+k, out_ready=1 -> out_valid rises 1 cycle after strobe; 96 consecutive beats, data 0x1000..0x105F, out_first on ch0, out_last on ch95, frame_id=0, then IDLE and busy=0.
- Backpressure: out_ready toggles 1,0,0,1 pattern -> every beat held stable while stalled; no channel skipped or duplicated; total of 96 transfers.
- Strobe arriving at beat 40 of a frame -> that frame completes intact from the original snapshot; ovf=1, drop_cnt=1; pulse ovf_clr -> ovf=0, drop_cnt=0.
- Strobe coincident with the ch95 transfer -> next cycle shows ch0 of the new frame, frame_id+1, no idle cycle, ovf stays 0.
- enable low with strobes every 64 cycles -> no output and no ovf; enable dropped mid-frame -> current frame finishes, then IDLE.
- rst asserted at beat 50 -> out_valid=0 immediately; after release, the next strobe yields frame_id=0 starting at ch0. Also 300 forced drops -> drop_cnt saturates at 255.
